// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core with one shared req/ready memory port and a debug register read.
// Define MULTI_CYCLE_CORE_PERF_EN to add the cycle_count / instret_count outputs.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        trap_cause,
    output logic [31:0]       pc_out,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata
`ifdef MULTI_CYCLE_CORE_PERF_EN
    ,
    output logic [63:0]       cycle_count,
    output logic [63:0]       instret_count
`endif
);

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExecute, StMemory, StWriteback, StTrap
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [31:0] mem_addr_full;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic        is_r, is_load, is_store, is_branch, is_jal, legal;
    logic [31:0] op_b, alu_res, eff_addr, pc_inc, br_tgt, jal_tgt;
    logic        br_taken;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    function automatic logic reg_ok(input logic [4:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    always_comb begin
        is_r      = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        legal     = 1'b0;
        case (opcode)
            OpcR: begin
                is_r  = 1'b1;
                legal = ((funct7 == 7'b0000000 && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}))
                        || (funct7 == 7'b0100000 && funct3 == 3'b000))
                        && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
            end
            OpcImm: begin
                legal = (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) && reg_ok(rd) && reg_ok(rs1);
            end
            OpcLoad: begin
                is_load = 1'b1;
                legal   = funct3 == 3'b010 && reg_ok(rd) && reg_ok(rs1);
            end
            OpcStore: begin
                is_store = 1'b1;
                legal    = funct3 == 3'b010 && reg_ok(rs1) && reg_ok(rs2);
            end
            OpcBranch: begin
                is_branch = 1'b1;
                legal     = (funct3 == 3'b000 || funct3 == 3'b001) && reg_ok(rs1) && reg_ok(rs2);
            end
            OpcJal: begin
                is_jal = 1'b1;
                legal  = reg_ok(rd);
            end
            default: ;
        endcase
    end

    assign op_b     = is_r ? b_q : imm_i;
    assign eff_addr = a_q + (is_store ? imm_s : imm_i);
    assign pc_inc   = pc_q + 32'd4;
    assign br_tgt   = pc_q + imm_b;
    assign jal_tgt  = pc_q + imm_j;
    assign br_taken = funct3[0] ? (a_q != b_q) : (a_q == b_q);

    always_comb begin
        case (funct3)
            3'b000:  alu_res = (is_r && funct7[5]) ? a_q - op_b : a_q + op_b;
            3'b111:  alu_res = a_q & op_b;
            3'b110:  alu_res = a_q | op_b;
            3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
            default: alu_res = 32'h0;
        endcase
    end

    // Outputs are forced to their idle values while rst is held, not just after the edge.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        a_d           = a_q;
        b_d           = b_q;
        res_d         = res_q;
        addr_d        = addr_q;
        cause_d       = cause_q;
        rf_we         = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_full = 32'h0;
        mem_wdata     = 32'h0;
        retire        = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req       = 1'b1;
                    mem_addr_full = pc_q;
                    if (mem_ready) begin
                        ir_d    = mem_rdata;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    a_d = rf_q[rs1];
                    b_d = rf_q[rs2];
                    if (legal) begin
                        state_d = StExecute;
                    end else begin
                        cause_d = 2'd1;
                        state_d = StTrap;
                    end
                end
                StExecute: begin
                    if (is_branch) begin
                        if (br_taken && br_tgt[1:0] != 2'b00) begin
                            cause_d = 2'd3;
                            state_d = StTrap;
                        end else begin
                            pc_d    = br_taken ? br_tgt : pc_inc;
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                    end else if (is_jal) begin
                        if (jal_tgt[1:0] != 2'b00) begin
                            cause_d = 2'd3;
                            state_d = StTrap;
                        end else begin
                            res_d   = pc_inc;
                            pc_d    = jal_tgt;
                            state_d = StWriteback;
                        end
                    end else if (is_load || is_store) begin
                        if (eff_addr[1:0] != 2'b00) begin
                            cause_d = 2'd2;
                            state_d = StTrap;
                        end else begin
                            addr_d  = eff_addr;
                            state_d = StMemory;
                        end
                    end else begin
                        res_d   = alu_res;
                        state_d = StWriteback;
                    end
                end
                StMemory: begin
                    mem_req       = 1'b1;
                    mem_we        = is_store;
                    mem_addr_full = addr_q;
                    mem_wdata     = is_store ? b_q : 32'h0;
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_d    = pc_inc;
                            retire  = 1'b1;
                            state_d = StFetch;
                        end else begin
                            res_d   = mem_rdata;
                            state_d = StWriteback;
                        end
                    end
                end
                StWriteback: begin
                    rf_we  = rd != 5'd0;
                    retire = 1'b1;
                    if (!is_jal) begin
                        pc_d = pc_inc;
                    end
                    state_d = StFetch;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            res_q   <= 32'h0;
            addr_q  <= 32'h0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (rf_we) begin
            rf_q[rd] <= res_q;
        end
    end

    assign mem_addr   = mem_addr_full[ADDR_W-1:0];
    assign halted     = state_q == StTrap;
    assign trap_cause = cause_q;
    assign pc_out     = pc_q;
    assign dbg_rdata  = (dbg_raddr == 5'd0 || 32'(dbg_raddr) >= NUM_REGS) ? 32'h0 : rf_q[dbg_raddr];

`ifdef MULTI_CYCLE_CORE_PERF_EN
    logic [63:0] cycle_q, cycle_d, instret_q, instret_d;

    always_comb begin
        cycle_d   = halted ? cycle_q : cycle_q + 64'd1;
        instret_d = retire ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule
